// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX/MEM and writeback: issues data-memory
// loads/stores, extracts/extends load data, and holds ECALLs until WB reports done.
module mem_stage #(
  parameter int REG_W = 6,
  parameter int XLEN  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EXMEM_valid,
  input  logic [REG_W-1:0] EXMEM_rd,
  input  logic [XLEN-1:0]  EXMEM_aluresult,
  input  logic [XLEN-1:0]  EXMEM_storedata,
  input  logic [1:0]       EXMEM_memop,
  input  logic [1:0]       EXMEM_size,
  input  logic             EXMEM_unsigned,
  input  logic             EXMEM_wbactive,
  input  logic             EXMEM_ecall,
  output logic             MEMEX_stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  output logic [7:0]       dmem_wstrb,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             WB_ecalldone,
  output logic [REG_W-1:0] MEMWB_rd,
  output logic [XLEN-1:0]  MEMWB_aluresult,
  output logic [XLEN-1:0]  MEMWB_loadeddata,
  output logic             MEMWB_dataselect,
  output logic             MEMWB_wbactive,
  output logic             MEMWB_ready,
  output logic             MEMWB_ecall
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MEM,
    S_WAIT_ECALL
  } state_t;

  state_t           r_state;
  logic             r_ecall_first;
  logic [REG_W-1:0] r_rd;
  logic [XLEN-1:0]  r_alu;
  logic             r_wb;
  logic             r_is_load;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic [2:0]       r_off;

  logic [2:0]       w_off;
  logic [7:0]       w_strb_base;
  logic [7:0]       w_wstrb;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_raw;
  logic [XLEN-1:0]  w_ext;
  logic             w_is_mem;
  logic             w_is_load;
  logic             w_rd_wb;

  assign MEMEX_stall = (r_state != S_IDLE);

  // Byte offset is forced down to the access-size alignment; accesses are never split.
  always_comb begin
    w_off       = 3'd0;
    w_strb_base = 8'h00;
    case (EXMEM_size)
      2'd0: begin w_off = EXMEM_aluresult[2:0];         w_strb_base = 8'h01; end
      2'd1: begin w_off = {EXMEM_aluresult[2:1], 1'b0}; w_strb_base = 8'h03; end
      2'd2: begin w_off = {EXMEM_aluresult[2], 2'b00};  w_strb_base = 8'h0F; end
      default: begin w_off = 3'd0;                      w_strb_base = 8'hFF; end
    endcase
    w_wstrb = w_strb_base << w_off;
    w_wdata = EXMEM_storedata << {w_off, 3'b000};
  end

  assign w_is_mem  = (EXMEM_memop == 2'd1) || (EXMEM_memop == 2'd2);
  assign w_is_load = (EXMEM_memop == 2'd1);
  assign w_rd_wb   = EXMEM_wbactive && (EXMEM_rd != '0);

  always_comb begin
    w_raw = dmem_rdata >> {r_off, 3'b000};
    w_ext = '0;
    case (r_size)
      2'd0: w_ext = r_unsigned ? {56'd0, w_raw[7:0]}  : {{56{w_raw[7]}},  w_raw[7:0]};
      2'd1: w_ext = r_unsigned ? {48'd0, w_raw[15:0]} : {{48{w_raw[15]}}, w_raw[15:0]};
      2'd2: w_ext = r_unsigned ? {32'd0, w_raw[31:0]} : {{32{w_raw[31]}}, w_raw[31:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_ecall_first    <= 1'b0;
      r_rd             <= '0;
      r_alu            <= '0;
      r_wb             <= 1'b0;
      r_is_load        <= 1'b0;
      r_size           <= '0;
      r_unsigned       <= 1'b0;
      r_off            <= '0;
      dmem_req         <= 1'b0;
      dmem_we          <= 1'b0;
      dmem_addr        <= '0;
      dmem_wdata       <= '0;
      dmem_wstrb       <= '0;
      MEMWB_rd         <= '0;
      MEMWB_aluresult  <= '0;
      MEMWB_loadeddata <= '0;
      MEMWB_dataselect <= 1'b0;
      MEMWB_wbactive   <= 1'b0;
      MEMWB_ready      <= 1'b0;
      MEMWB_ecall      <= 1'b0;
    end else begin
      MEMWB_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (EXMEM_valid) begin
            if (EXMEM_ecall) begin
              MEMWB_ready      <= 1'b1;
              MEMWB_ecall      <= 1'b1;
              MEMWB_wbactive   <= 1'b0;
              MEMWB_dataselect <= 1'b0;
              MEMWB_rd         <= EXMEM_rd;
              MEMWB_aluresult  <= EXMEM_aluresult;
              r_ecall_first    <= 1'b1;
              r_state          <= S_WAIT_ECALL;
            end else if (w_is_mem) begin
              r_rd       <= EXMEM_rd;
              r_alu      <= EXMEM_aluresult;
              r_wb       <= w_rd_wb;
              r_is_load  <= w_is_load;
              r_size     <= EXMEM_size;
              r_unsigned <= EXMEM_unsigned;
              r_off      <= w_off;
              dmem_req   <= 1'b1;
              dmem_we    <= ~w_is_load;
              dmem_addr  <= {EXMEM_aluresult[XLEN-1:3], 3'b000};
              dmem_wdata <= w_wdata;
              dmem_wstrb <= w_is_load ? 8'h00 : w_wstrb;
              r_state    <= S_WAIT_MEM;
            end else begin
              MEMWB_ready      <= 1'b1;
              MEMWB_ecall      <= 1'b0;
              MEMWB_rd         <= EXMEM_rd;
              MEMWB_aluresult  <= EXMEM_aluresult;
              MEMWB_dataselect <= 1'b0;
              MEMWB_wbactive   <= w_rd_wb;
            end
          end
        end
        S_WAIT_MEM: begin
          if (dmem_ack) begin
            dmem_req         <= 1'b0;
            MEMWB_ready      <= 1'b1;
            MEMWB_ecall      <= 1'b0;
            MEMWB_rd         <= r_rd;
            MEMWB_aluresult  <= r_alu;
            MEMWB_dataselect <= r_is_load;
            MEMWB_wbactive   <= r_is_load && r_wb;
            if (r_is_load)
              MEMWB_loadeddata <= w_ext;
            r_state          <= S_IDLE;
          end
        end
        S_WAIT_ECALL: begin
          // The retire-pulse cycle cannot observe a completion for this ecall.
          r_ecall_first <= 1'b0;
          if (!r_ecall_first && WB_ecalldone)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
